// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// == Module   : maxnet_pkg                                                   ==
// == Purpose  : Shared definitions for the MaxNet winner-take-all engine:    ==
// ==            controller state encodings and a constant-safe clog2 used    ==
// ==            to size ports and internal datapaths.                        ==
// == Ports    : none (package)                                               ==
// == Revision : 1.0 - initial release                                        ==
// ============================================================================
package maxnet_pkg;

    // Controller state encoding
    localparam int         STATE_W = 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Ceiling log2; clog2(1) = 0, so a single-channel engine sizes cleanly.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage : maxnet_pkg
`default_nettype wire

// File: rtl/maxnet_neuron.sv
`default_nettype none
// ============================================================================
// == Module   : maxnet_neuron                                                ==
// == Purpose  : One MaxNet channel update. Given this channel's activation,  ==
// ==            the sum of all activations and the inhibition weight, it     ==
// ==            produces the next activation, clipped at zero.               ==
// == Ports    : act  in  WIDTH  current activation (always >= 0)            ==
// ==            sum  in  SUM_W  sum of all activations                       ==
// ==            eps  in  WIDTH  unsigned Q.FRAC inhibition weight            ==
// ==            next out WIDTH  updated activation (>= 0)                    ==
// == Revision : 1.0 - initial release                                        ==
// ============================================================================
module maxnet_neuron #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int SUM_W = 18
) (
    input  logic [WIDTH-1:0] act,
    input  logic [SUM_W-1:0] sum,
    input  logic [WIDTH-1:0] eps,
    output logic [WIDTH-1:0] next
);

    localparam int PROD_W = SUM_W + WIDTH;
    localparam int INH_W  = PROD_W - FRAC;
    // Adding 2^FRAC-1 before the shift turns the truncating shift into a
    // ceiling, so any non-zero inhibition removes at least one LSB and the
    // iteration always makes progress.
    localparam logic [PROD_W-1:0] C_ROUND = PROD_W'((64'd1 << FRAC) - 64'd1);

    logic [SUM_W-1:0]  w_oth;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_round;
    logic [INH_W-1:0]  w_inh;

    // Activations are non-negative and sum >= act, so everything here is
    // an unsigned quantity and the product never wraps.
    assign w_oth   = sum - SUM_W'(act);
    assign w_prod  = PROD_W'(w_oth) * PROD_W'(eps);
    assign w_round = w_prod + C_ROUND;
    assign w_inh   = INH_W'(w_round >> FRAC);

    // When inhibition is smaller than act it fits in WIDTH bits.
    assign next = (w_inh >= INH_W'(act)) ? '0 : (act - w_inh[WIDTH-1:0]);

endmodule : maxnet_neuron
`default_nettype wire

// File: rtl/maxnet_engine.sv
`default_nettype none
// ============================================================================
// == Module   : maxnet_engine                                               ==
// == Purpose  : Parametrised MaxNet winner-take-all engine with built-in    ==
// ==            controller. Each iteration every channel is inhibited by    ==
// ==            epsilon times the sum of the others until at most one       ==
// ==            channel remains positive or the iteration cap is reached.   ==
// == Ports    : clk, rst            clock, synchronous active-high reset    ==
// ==            start/ready/done    request / idle / one-cycle completion   ==
// ==            epsilon, x_in       weight and packed candidates at accept  ==
// ==            found, timeout      single survivor / capped with >=2 left  ==
// ==            max_index/value     winner channel and its original input   ==
// ==            iterations          update iterations performed             ==
// == Revision : 1.0 - initial release                                       ==
// ============================================================================
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int WIDTH    = 16,
    parameter  int FRAC     = 8,
    parameter  int MAX_ITER = 63,
    localparam int IDX_W    = (clog2(N) > 1) ? clog2(N) : 1,
    localparam int ITER_W   = clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     epsilon,
    input  logic [N*WIDTH-1:0]   x_in,
    output logic                 ready,
    output logic                 done,
    output logic                 found,
    output logic                 timeout,
    output logic [IDX_W-1:0]     max_index,
    output logic [WIDTH-1:0]     max_value,
    output logic [ITER_W-1:0]    iterations
);

    localparam int SUM_W = WIDTH + clog2(N);
    localparam int CNT_W = clog2(N + 1);

    logic [STATE_W-1:0] r_state;
    logic [N*WIDTH-1:0] r_x;
    logic [WIDTH-1:0]   r_eps;
    logic [WIDTH-1:0]   r_act [N];
    logic [ITER_W-1:0]  r_iter;

    logic               r_ready;
    logic               r_done;
    logic               r_found;
    logic               r_timeout;
    logic [IDX_W-1:0]   r_max_index;
    logic [WIDTH-1:0]   r_max_value;
    logic [ITER_W-1:0]  r_iterations;

    logic [SUM_W-1:0]   w_sum;
    logic [CNT_W-1:0]   w_pos;
    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_sel_x;
    logic [WIDTH-1:0]   w_next [N];
    logic               w_found;
    logic               w_multi;

    // Activations are stored non-negative, so "positive" is simply non-zero.
    always_comb begin
        w_sum = '0;
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + SUM_W'(r_act[i]);
            if (r_act[i] != '0) begin
                w_pos = w_pos + CNT_W'(1);
            end
        end
    end

    // Lowest-index positive channel wins; scanning downward lets the lowest
    // index overwrite any higher one.
    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_act[i] != '0) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_x = '0;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == w_idx) begin
                w_sel_x = r_x[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_found = (w_pos == CNT_W'(1));
    assign w_multi = (w_pos > CNT_W'(1));

    for (genvar g = 0; g < N; g++) begin : g_neuron
        maxnet_neuron #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .SUM_W (SUM_W)
        ) u_neuron (
            .act  (r_act[g]),
            .sum  (w_sum),
            .eps  (r_eps),
            .next (w_next[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_eps        <= '0;
            r_iter       <= '0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_timeout    <= 1'b0;
            r_max_index  <= '0;
            r_max_value  <= '0;
            r_iterations <= '0;
            for (int i = 0; i < N; i++) begin
                r_act[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x     <= x_in;
                        r_eps   <= epsilon;
                        r_iter  <= '0;
                        r_ready <= 1'b0;
                        r_state <= ST_RUN;
                        // ReLU on load: negative candidates start at zero.
                        for (int i = 0; i < N; i++) begin
                            r_act[i] <= x_in[i*WIDTH + WIDTH - 1] ? '0 : x_in[i*WIDTH +: WIDTH];
                        end
                    end
                end
                ST_RUN: begin
                    if ((w_pos <= CNT_W'(1)) || (r_iter == ITER_W'(MAX_ITER))) begin
                        r_found      <= w_found;
                        r_timeout    <= w_multi;
                        r_max_index  <= w_idx;
                        r_max_value  <= w_found ? w_sel_x : '0;
                        r_iterations <= r_iter;
                        r_done       <= 1'b1;
                        r_ready      <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            r_act[i] <= w_next[i];
                        end
                        r_iter <= r_iter + ITER_W'(1);
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign done       = r_done;
    assign found      = r_found;
    assign timeout    = r_timeout;
    assign max_index  = r_max_index;
    assign max_value  = r_max_value;
    assign iterations = r_iterations;

endmodule : maxnet_engine
`default_nettype wire

// File: tb/tb_maxnet_engine.sv
`default_nettype none
// ============================================================================
// == Module   : tb_maxnet_engine                                            ==
// == Purpose  : Self-checking bench for maxnet_engine. Expected results are ==
// ==            queued when a request is accepted and compared, together    ==
// ==            with completion latency, when done pulses.                  ==
// == Ports    : none (top-level bench)                                      ==
// == Revision : 1.0 - initial release                                       ==
// ============================================================================
module tb_maxnet_engine;

    localparam int N        = 4;
    localparam int WIDTH    = 16;
    localparam int FRAC     = 8;
    localparam int MAX_ITER = 63;
    localparam int IDX_W    = 2;
    localparam int ITER_W   = 6;

    typedef struct {
        logic             found;
        logic             timeout;
        int               idx;
        logic [WIDTH-1:0] value;
        int               iters;
        int               lat;
        int               start_cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    epsilon;
    logic [N*WIDTH-1:0]  x_in;
    logic                ready;
    logic                done;
    logic                found;
    logic                timeout;
    logic [IDX_W-1:0]    max_index;
    logic [WIDTH-1:0]    max_value;
    logic [ITER_W-1:0]   iterations;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    maxnet_engine #(
        .N        (N),
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .epsilon    (epsilon),
        .x_in       (x_in),
        .ready      (ready),
        .done       (done),
        .found      (found),
        .timeout    (timeout),
        .max_index  (max_index),
        .max_value  (max_value),
        .iterations (iterations)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*WIDTH-1:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                                 input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic exp_t mk(input logic f, input logic t, input int idx,
                                input logic [15:0] v, input int it);
        exp_t e;
        e.found = f; e.timeout = t; e.idx = idx; e.value = v;
        e.iters = it; e.lat = it + 2; e.start_cyc = 0;
        return e;
    endfunction

    // Reference MaxNet in plain integer arithmetic.
    function automatic exp_t model(input logic [N*WIDTH-1:0] x, input logic [WIDTH-1:0] eps);
        longint act[N];
        longint nxt[N];
        longint s, oth, inh, xv;
        int     iter, pos, idx;
        exp_t   e;
        for (int i = 0; i < N; i++) begin
            xv = longint'($signed(x[i*WIDTH +: WIDTH]));
            act[i] = (xv > 0) ? xv : 0;
        end
        iter = 0;
        while (1) begin
            pos = 0;
            for (int i = 0; i < N; i++) if (act[i] > 0) pos++;
            if (pos <= 1 || iter == MAX_ITER) break;
            s = 0;
            for (int i = 0; i < N; i++) s += act[i];
            for (int i = 0; i < N; i++) begin
                oth = s - act[i];
                inh = (oth * longint'(eps) + (1 << FRAC) - 1) / (1 << FRAC);
                nxt[i] = (act[i] - inh > 0) ? act[i] - inh : 0;
            end
            for (int i = 0; i < N; i++) act[i] = nxt[i];
            iter++;
        end
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (act[i] > 0) idx = i;
        e = mk(pos == 1, pos >= 2, idx, (pos == 1) ? x[idx*WIDTH +: WIDTH] : '0, iter);
        return e;
    endfunction

    // Scoreboard consumer: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check_val("unexpected_done", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check_val("found",      found,      mon_e.found);
                check_val("timeout",    timeout,    mon_e.timeout);
                check_val("max_index",  max_index,  mon_e.idx);
                check_val("max_value",  max_value,  mon_e.value);
                check_val("iterations", iterations, mon_e.iters);
                check_val("latency",    cyc - mon_e.start_cyc, mon_e.lat);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_case(input logic [N*WIDTH-1:0] x, input logic [WIDTH-1:0] eps,
                              input exp_t e_in);
        int   w;
        exp_t e;
        w = 0;
        while (!ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check_val("ready_timeout", 0, 1);
        start   = 1'b1;
        x_in    = x;
        epsilon = eps;
        e = e_in;
        e.start_cyc = cyc;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check_val("busy_ready", ready, 0);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (q.size() != 0) begin
            check_val("done_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"},      ready,      1);
        check_val({tag, "_done"},       done,       0);
        check_val({tag, "_found"},      found,      0);
        check_val({tag, "_timeout"},    timeout,    0);
        check_val({tag, "_max_index"},  max_index,  0);
        check_val({tag, "_max_value"},  max_value,  0);
        check_val({tag, "_iterations"}, iterations, 0);
    endtask

    logic [N*WIDTH-1:0] t1_x;
    logic [N*WIDTH-1:0] rx;
    logic [WIDTH-1:0]   rv;
    int                 v;

    initial begin
        rst = 1'b1; start = 1'b0; x_in = '0; epsilon = '0;
        t1_x = pack4(16'h0300, 16'h0100, 16'h0200, 16'h0080);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-derived results
        start_case(t1_x, 16'h0040, mk(1'b1, 1'b0, 0, 16'h0300, 3));
        wait_drain();
        start_case(pack4(16'hFF00, 16'h0000, 16'h0080, 16'h0000), 16'h0040,
                   mk(1'b1, 1'b0, 2, 16'h0080, 0));
        wait_drain();
        start_case(pack4(16'h0200, 16'h0200, 16'h0100, 16'h0000), 16'h0040,
                   mk(1'b0, 1'b0, 0, 16'h0000, 19));
        wait_drain();
        start_case(pack4(16'h0100, 16'h0200, 16'h0000, 16'h0000), 16'h0000,
                   mk(1'b0, 1'b1, 0, 16'h0000, 63));
        wait_drain();
        start_case(pack4(16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80), 16'h0040,
                   mk(1'b0, 1'b0, 0, 16'h0000, 0));
        wait_drain();

        // Random candidates against the reference model
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                v = int'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) == 0) v = -v;
                rv = 16'(v);
                rx[i*WIDTH +: WIDTH] = rv;
            end
            rv = 16'($urandom_range(16, 160));
            start_case(rx, rv, model(rx, rv));
            wait_drain();
        end

        // Reset mid-run aborts without done
        start_case(t1_x, 16'h0040, mk(1'b1, 1'b0, 0, 16'h0300, 3));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        q.delete();
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Start pulsed while busy is ignored; a fresh run reproduces case 1
        start_case(t1_x, 16'h0040, mk(1'b1, 1'b0, 0, 16'h0300, 3));
        start = 1'b1;
        x_in  = pack4(16'hFF00, 16'h0000, 16'h0080, 16'h0000);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_maxnet_engine
`default_nettype wire
